// File: rtl/pwl_jerk_integrator_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pwl_jerk_integrator_if                                           |
// | Purpose  : Host-side bundle of the jerk integrator: load/start controls,    |
// |            runtime coefficients, state outputs and status flags.           |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface pwl_jerk_integrator_if #(
  parameter int W = 22
);
  logic                load_enable;
  logic signed [W-1:0] x0;
  logic signed [W-1:0] y0;
  logic signed [W-1:0] z0;
  logic                start;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;
  logic signed [W-1:0] d;
  logic signed [W-1:0] q;
  logic signed [W-1:0] m;
  logic signed [W-1:0] dt;
  logic                busy;
  logic                done;
  logic signed [W-1:0] o_x;
  logic signed [W-1:0] o_y;
  logic signed [W-1:0] o_z;
  logic                ovf;

  // Host / load logic side
  modport master (
    output load_enable, x0, y0, z0, start, a, b, c, d, q, m, dt,
    input  busy, done, o_x, o_y, o_z, ovf
  );

  // Integrator side
  modport slave (
    input  load_enable, x0, y0, z0, start, a, b, c, d, q, m, dt,
    output busy, done, o_x, o_y, o_z, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pwl_jerk_integrator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pwl_jerk_integrator                                              |
// | Purpose  : Time-multiplexed explicit-Euler step of the piecewise-linear     |
// |            jerk system x'=y, y'=z, z'=d*f(x)-a*x-b*y-c*z using one shared  |
// |            signed multiplier sequenced over eight cycles.                  |
// | Options  : PWL_SAT_EN - defined: every width reduction saturates;          |
// |            undefined: reductions wrap (two's-complement truncation).       |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module pwl_jerk_integrator #(
  parameter int W    = 22,
  parameter int FRAC = 18,
  parameter int INIT = 26214
) (
  input  logic                 clk,
  input  logic                 reset,
  pwl_jerk_integrator_if.slave bus
);

  localparam int PW = 2 * W;
  localparam int AW = W + 3;

  localparam logic signed [PW-1:0] C_MAX  = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] C_MIN  = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  C_ONE  = W'(1 << FRAC);
  localparam logic signed [W-1:0]  C_INIT = W'(INIT);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_NL   = 4'd1,
    S_D    = 4'd2,
    S_A    = 4'd3,
    S_B    = 4'd4,
    S_C    = 4'd5,
    S_UX   = 4'd6,
    S_UY   = 4'd7,
    S_UZ   = 4'd8
  } state_t;

  // Narrow a sign-extended value to W bits; MSB of the result flags a value change.
  function automatic logic [W:0] reduce(input logic signed [PW-1:0] v);
    logic         ov;
    logic [W-1:0] r;
    ov = (v > C_MAX) || (v < C_MIN);
    r  = v[W-1:0];
`ifdef PWL_SAT_EN
    if (v > C_MAX)      r = C_MAX[W-1:0];
    else if (v < C_MIN) r = C_MIN[W-1:0];
`endif
    return {ov, r};
  endfunction

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [W-1:0] xn_q, xn_d, yn_q, yn_d;
  logic signed [W-1:0] f_q, f_d, fz_q, fz_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic signed [W-1:0] q_q, q_d, m_q, m_d, dt_q, dt_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic signed [W-1:0]  w_mul_a, w_mul_b, w_base;
  logic signed [PW-1:0] w_prod, w_prod_sh;
  logic signed [W-1:0]  w_prod_red;
  logic                 w_prod_ovf;
  logic signed [AW-1:0] w_prod_ext, w_acc_next;
  logic signed [W-1:0]  w_fz_red;
  logic                 w_fz_ovf;
  logic signed [W:0]    w_sum;
  logic signed [W-1:0]  w_sum_red;
  logic                 w_sum_ovf;
  logic signed [W:0]    w_x_ext, w_nq;
  logic                 w_x_ge_q, w_x_le_nq;

  // Route the operand pair for the single multiply of the current step phase.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    w_base  = z_q;
    case (state_q)
      S_NL: begin w_mul_a = m_q;  w_mul_b = x_q;  end
      S_D:  begin w_mul_a = d_q;  w_mul_b = f_q;  end
      S_A:  begin w_mul_a = a_q;  w_mul_b = x_q;  end
      S_B:  begin w_mul_a = b_q;  w_mul_b = y_q;  end
      S_C:  begin w_mul_a = c_q;  w_mul_b = z_q;  end
      S_UX: begin w_mul_a = dt_q; w_mul_b = y_q;  w_base = x_q; end
      S_UY: begin w_mul_a = dt_q; w_mul_b = z_q;  w_base = y_q; end
      S_UZ: begin w_mul_a = dt_q; w_mul_b = fz_q; w_base = z_q; end
      default: ;
    endcase
  end

  // Product is floored back to Q format, then narrowed to W bits.
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_prod_sh = w_prod >>> FRAC;
  assign {w_prod_ovf, w_prod_red} = reduce(w_prod_sh);
  assign w_prod_ext = {{3{w_prod_red[W-1]}}, w_prod_red};

  // D starts a fresh accumulation; A, B, C subtract from it.
  assign w_acc_next = (state_q == S_D) ? w_prod_ext : (acc_q - w_prod_ext);
  assign {w_fz_ovf, w_fz_red} = reduce({{(PW-AW){w_acc_next[AW-1]}}, w_acc_next});

  // State update sum shared by the three Euler phases.
  assign w_sum = {w_base[W-1], w_base} + {w_prod_red[W-1], w_prod_red};
  assign {w_sum_ovf, w_sum_red} = reduce({{(PW-W-1){w_sum[W]}}, w_sum});

  // Breakpoint comparisons; -q is formed one bit wider so it cannot overflow.
  assign w_x_ext   = {x_q[W-1], x_q};
  assign w_nq      = -{q_q[W-1], q_q};
  assign w_x_ge_q  = (x_q >= q_q);
  assign w_x_le_nq = (w_x_ext <= w_nq);

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xn_d    = xn_q;
    yn_d    = yn_q;
    f_d     = f_q;
    fz_d    = fz_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    q_d     = q_q;
    m_d     = m_q;
    dt_d    = dt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load_enable) begin
          x_d = bus.x0;
          y_d = bus.y0;
          z_d = bus.z0;
        end else if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          d_d     = bus.d;
          q_d     = bus.q;
          m_d     = bus.m;
          dt_d    = bus.dt;
          state_d = S_NL;
        end
      end
      S_NL: begin
        if (w_x_ge_q) begin
          f_d = C_ONE;
        end else if (w_x_le_nq) begin
          f_d = -C_ONE;
        end else begin
          f_d   = w_prod_red;
          ovf_d = ovf_q | w_prod_ovf;
        end
        state_d = S_D;
      end
      S_D: begin
        acc_d   = w_acc_next;
        ovf_d   = ovf_q | w_prod_ovf;
        state_d = S_A;
      end
      S_A: begin
        acc_d   = w_acc_next;
        ovf_d   = ovf_q | w_prod_ovf;
        state_d = S_B;
      end
      S_B: begin
        acc_d   = w_acc_next;
        ovf_d   = ovf_q | w_prod_ovf;
        state_d = S_C;
      end
      S_C: begin
        acc_d   = w_acc_next;
        fz_d    = w_fz_red;
        ovf_d   = ovf_q | w_prod_ovf | w_fz_ovf;
        state_d = S_UX;
      end
      S_UX: begin
        xn_d    = w_sum_red;
        ovf_d   = ovf_q | w_prod_ovf | w_sum_ovf;
        state_d = S_UY;
      end
      S_UY: begin
        yn_d    = w_sum_red;
        ovf_d   = ovf_q | w_prod_ovf | w_sum_ovf;
        state_d = S_UZ;
      end
      S_UZ: begin
        // All three states commit together so every update saw old values.
        x_d     = xn_q;
        y_d     = yn_q;
        z_d     = w_sum_red;
        ovf_d   = ovf_q | w_prod_ovf | w_sum_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= C_INIT;
      y_q     <= C_INIT;
      z_q     <= C_INIT;
      xn_q    <= '0;
      yn_q    <= '0;
      f_q     <= '0;
      fz_q    <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      dt_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xn_q    <= xn_d;
      yn_q    <= yn_d;
      f_q     <= f_d;
      fz_q    <= fz_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      q_q     <= q_d;
      m_q     <= m_d;
      dt_q    <= dt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.o_x  = x_q;
  assign bus.o_y  = y_q;
  assign bus.o_z  = z_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire
